// File: rtl/game_led_pkg.sv
// game_led_pkg: shared opcodes, state encoding and display constants for the LED controller
package game_led_pkg;
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_SCORE = 2'b01;
    localparam logic [1:0] OP_WIN   = 2'b10;
    localparam logic [1:0] OP_RAW   = 2'b11;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int MAX_DIGIT = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ANIM, ST_HOLD} state_t;
    function automatic logic [3:0] thermo(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction
endpackage

// File: rtl/game_led_ctrl_if.sv
// game_led_ctrl_if: PIO command word in, LED/digit/status drive out
interface game_led_ctrl_if;
    logic [9:0] pio_word;
    logic [9:0] ledr;
    logic [6:0] hex_bulls;
    logic [6:0] hex_cows;
    logic       busy;
    logic       cmd_err;
    modport master (output pio_word, input ledr, hex_bulls, hex_cows, busy, cmd_err);
    modport slave  (input pio_word, output ledr, hex_bulls, hex_cows, busy, cmd_err);
endinterface

// File: rtl/game_led_ctrl_seg7.sv
// seg7_digit: 0..4 to active-low gfedcba pattern, blank when invalid or out of range
module seg7_digit
    import game_led_pkg::*;
(
    input  logic [2:0] val_i,
    input  logic       vld_i,
    output logic [6:0] seg_o
);
    always_comb
        seg_o = (!vld_i || val_i > 3'(MAX_DIGIT)) ? SEG_BLANK :
                val_i == 3'd0 ? 7'h40 :
                val_i == 3'd1 ? 7'h79 :
                val_i == 3'd2 ? 7'h24 :
                val_i == 3'd3 ? 7'h30 : 7'h19;
endmodule

// File: rtl/game_led_ctrl.sv
// game_led_ctrl: toggle-strobed PIO command decoder driving LEDs, score digits and a win animation
module game_led_ctrl
    import game_led_pkg::*;
#(
    parameter int TICK_DIV  = 5000000,
    parameter int WIN_STEPS = 20
) (
    input logic            clk_clk,
    input logic            reset_reset_n,
    game_led_ctrl_if.slave led_if
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [9:0]    word_q, ledr_q, ledr_d;
    logic          last_tog_q, last_tog_d;
    state_t        state_q, state_d;
    logic [2:0]    bulls_q, bulls_d, cows_q, cows_d;
    logic          vld_q, vld_d, busy_q, busy_d, err_q, err_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [4:0]    step_q, step_d;
    logic [6:0]    hex_b_q, hex_c_q, hex_b_d, hex_c_d;
    logic          cmd, score_ok, tick_end;
    logic [1:0]    op;
    logic [6:0]    pay;

    assign cmd      = word_q[9] != last_tog_q;
    assign op       = word_q[8:7];
    assign pay      = word_q[6:0];
    assign score_ok = {1'b0, pay[5:3]} + {1'b0, pay[2:0]} <= 4'(MAX_DIGIT);
    assign tick_end = state_q == ST_ANIM && tick_q == TW'(TICK_DIV - 1);

    // Animation advances first; an accepted command then overrides, so CLEAR beats the final tick
    always_comb begin
        last_tog_d = cmd ? word_q[9] : last_tog_q;
        state_d    = state_q;
        ledr_d     = ledr_q;
        bulls_d    = bulls_q;
        cows_d     = cows_q;
        vld_d      = vld_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        tick_d     = state_q == ST_ANIM ? (tick_end ? '0 : tick_q + 1'b1) : tick_q;
        step_d     = step_q;
        if (tick_end) begin
            state_d = step_q == 5'(WIN_STEPS - 1) ? ST_HOLD : ST_ANIM;
            ledr_d  = step_q == 5'(WIN_STEPS - 1) ? 10'h3FF : {ledr_q[8:0], ledr_q[9]};
            busy_d  = step_q != 5'(WIN_STEPS - 1);
            step_d  = step_q == 5'(WIN_STEPS - 1) ? 5'd0 : step_q + 5'd1;
        end
        if (cmd) begin
            if (op == OP_CLEAR) begin
                state_d = ST_IDLE;
                ledr_d  = '0;
                bulls_d = '0;
                cows_d  = '0;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
                tick_d  = '0;
                step_d  = '0;
            end else if (state_q == ST_ANIM || (op == OP_SCORE && !score_ok)) begin
                err_d = 1'b1;
            end else if (op == OP_SCORE) begin
                state_d = ST_IDLE;
                bulls_d = pay[5:3];
                cows_d  = pay[2:0];
                vld_d   = 1'b1;
                ledr_d  = {6'b0, thermo(pay[5:3])};
            end else if (op == OP_WIN) begin
                state_d = ST_ANIM;
                ledr_d  = 10'h001;
                busy_d  = 1'b1;
                tick_d  = '0;
                step_d  = '0;
            end else begin
                state_d = ST_IDLE;
                ledr_d  = {3'b0, pay};
            end
        end
    end

    seg7_digit u_bulls (.val_i(bulls_d), .vld_i(vld_d), .seg_o(hex_b_d));
    seg7_digit u_cows  (.val_i(cows_d),  .vld_i(vld_d), .seg_o(hex_c_d));

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            word_q     <= led_if.pio_word;
            last_tog_q <= led_if.pio_word[9];
            state_q    <= ST_IDLE;
            ledr_q     <= '0;
            bulls_q    <= '0;
            cows_q     <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= '0;
            step_q     <= '0;
            hex_b_q    <= SEG_BLANK;
            hex_c_q    <= SEG_BLANK;
        end else begin
            word_q     <= led_if.pio_word;
            last_tog_q <= last_tog_d;
            state_q    <= state_d;
            ledr_q     <= ledr_d;
            bulls_q    <= bulls_d;
            cows_q     <= cows_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
            hex_b_q    <= hex_b_d;
            hex_c_q    <= hex_c_d;
        end
    end

    assign led_if.ledr      = ledr_q;
    assign led_if.hex_bulls = hex_b_q;
    assign led_if.hex_cows  = hex_c_q;
    assign led_if.busy      = busy_q;
    assign led_if.cmd_err   = err_q;
endmodule

// File: tb/tb_game_led_ctrl.sv
// tb_game_led_ctrl: directed and random commands checked every cycle against a transaction-level model
module tb_game_led_ctrl;
    import game_led_pkg::*;
    localparam int TD = 4;
    localparam int WS = 20;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    game_led_ctrl_if led_if ();

    game_led_ctrl #(.TICK_DIV(TD), .WIN_STEPS(WS)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .led_if       (led_if.slave)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] m_ledr;
    logic [2:0] m_b, m_c;
    logic m_vld, m_anim, m_err;
    int m_start;
    bit pend;
    int pend_at;
    logic [9:0] pend_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    endtask

    function automatic logic [6:0] seg(input logic [2:0] v, input logic vld);
        logic [6:0] t [5];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
        return (!vld || v > 3'd4) ? 7'h7F : t[v];
    endfunction

    function automatic int ticks(input int c);
        return (c - m_start) / TD;
    endfunction

    task automatic model_reset();
        m_ledr = '0; m_b = '0; m_c = '0; m_vld = 0; m_anim = 0; m_err = 0; pend = 0;
    endtask

    // The command takes effect at edge cyc; the machine state it sees is that left by edge cyc-1
    task automatic apply(input logic [9:0] w);
        logic [1:0] op;
        op = w[8:7];
        if (m_anim && ticks(cyc - 1) >= WS) begin m_anim = 0; m_ledr = '1; end
        m_err = 0;
        if (op == OP_CLEAR) begin
            m_anim = 0; m_ledr = '0; m_vld = 0;
        end else if (m_anim) m_err = 1;
        else if (op == OP_SCORE) begin
            if (int'(w[5:3]) + int'(w[2:0]) > MAX_DIGIT) m_err = 1;
            else begin
                m_b = w[5:3]; m_c = w[2:0]; m_vld = 1;
                m_ledr = 10'((1 << w[5:3]) - 1);
            end
        end else if (op == OP_WIN) begin
            m_anim = 1; m_start = cyc;
        end else m_ledr = {3'b0, w[6:0]};
    endtask

    task automatic step();
        logic [9:0] el;
        logic eb, ee;
        int t;
        @(negedge clk_clk);
        ee = 0;
        if (pend && cyc == pend_at) begin apply(pend_word); pend = 0; ee = m_err; end
        if (m_anim) begin
            t = ticks(cyc);
            el = t >= WS ? 10'h3FF : 10'(1 << (t % 10));
            eb = t < WS;
        end else begin
            el = m_ledr; eb = 0;
        end
        chk("ledr", 32'(led_if.ledr), 32'(el));
        chk("hex_bulls", 32'(led_if.hex_bulls), 32'(seg(m_b, m_vld)));
        chk("hex_cows", 32'(led_if.hex_cows), 32'(seg(m_c, m_vld)));
        chk("busy", 32'(led_if.busy), 32'(eb));
        chk("cmd_err", 32'(led_if.cmd_err), 32'(ee));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cmd(input logic [1:0] op, input logic [6:0] pay);
        led_if.pio_word = {~led_if.pio_word[9], op, pay};
        pend = 1; pend_at = cyc + 2; pend_word = led_if.pio_word;
    endtask

    task automatic do_reset(input int n);
        reset_reset_n = 1'b0;
        model_reset();
        run(n);
        reset_reset_n = 1'b1;
    endtask

    initial begin
        int s, b, c;
        logic [1:0] op;
        logic [6:0] pay;
        led_if.pio_word = 10'h200;
        model_reset();
        run(3);
        reset_reset_n = 1'b1;
        run(4);
        cmd(OP_SCORE, 7'h11); run(3);
        cmd(OP_SCORE, 7'h1B); run(3);
        cmd(OP_WIN, 7'h00); run(2);
        s = m_start;
        run(30);
        cmd(OP_RAW, 7'h55); run(3);
        while (cyc < s + WS * TD + 4) step();
        cmd(OP_SCORE, 7'h21); run(3);
        cmd(OP_WIN, 7'h00); run(2);
        s = m_start;
        while (cyc < s + WS * TD - 2) step();
        cmd(OP_CLEAR, 7'h00); run(4);
        cmd(OP_WIN, 7'h00); run(20);
        cmd(OP_CLEAR, 7'h00); run(3);
        cmd(OP_WIN, 7'h00); run(30);
        do_reset(3); run(5);
        cmd(OP_RAW, 7'h55); run(3);
        cmd(OP_SCORE, 7'h20); run(3);
        cmd(OP_SCORE, 7'h04); run(3);
        cmd(OP_SCORE, 7'h28); run(3);
        cmd(OP_WIN, 7'h00); run(WS * TD + 4);
        cmd(OP_WIN, 7'h00); run(10);
        for (int i = 0; i < 120; i++) begin
            op = 2'($urandom_range(0, 3));
            pay = 7'($urandom);
            if (op == OP_SCORE && $urandom_range(0, 1) == 1) begin
                b = $urandom_range(0, 4);
                c = $urandom_range(0, 4 - b);
                pay = {pay[6], 3'(b), 3'(c)};
            end
            cmd(op, pay);
            run(2);
            repeat ($urandom_range(0, 40)) begin
                if ($urandom_range(0, 3) == 0) led_if.pio_word[8:0] = 9'($urandom);
                step();
            end
            if ($urandom_range(0, 24) == 0) begin do_reset(2); run(2); end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
